// File: rtl/rx_iq_pkg.sv
// rtl/rx_iq_pkg.sv - shared RX I/Q sizing constants
package rx_iq_pkg;
    localparam int IQ_W    = 32;
    localparam int DEPTH   = 32;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int WORD_W  = 2 * IQ_W;
    localparam int LEVEL_W = 6;
endpackage

// File: rtl/rx_iq_fifo_if.sv
// rtl/rx_iq_fifo_if.sv - decimator/bus-side signal bundle for the RX I/Q FIFO
interface rx_iq_fifo_if
    import rx_iq_pkg::*;
#(
    parameter int IQ_W = rx_iq_pkg::IQ_W
) ();
    logic signed [IQ_W-1:0] RX_I_in;
    logic signed [IQ_W-1:0] RX_Q_in;
    logic                   iq_valid;
    logic                   IQ_RX_READ_REQ;
    logic                   IQ_RX_READ_CLK;
    logic                   overrun_clear;
    logic signed [IQ_W-1:0] RX_I;
    logic signed [IQ_W-1:0] RX_Q;
    logic [LEVEL_W-1:0]     fifo_level;
    logic                   iq_overrun;
    logic                   iq_underrun;

    modport master (
        output RX_I_in, RX_Q_in, iq_valid, IQ_RX_READ_REQ, IQ_RX_READ_CLK, overrun_clear,
        input  RX_I, RX_Q, fifo_level, iq_overrun, iq_underrun
    );

    modport slave (
        input  RX_I_in, RX_Q_in, iq_valid, IQ_RX_READ_REQ, IQ_RX_READ_CLK, overrun_clear,
        output RX_I, RX_Q, fifo_level, iq_overrun, iq_underrun
    );
endinterface

// File: rtl/iq_dpram.sv
// rtl/iq_dpram.sv - simple dual-port RAM, registered write and read, new-data bypass
module iq_dpram #(
    parameter int DEPTH = rx_iq_pkg::DEPTH,
    parameter int W     = rx_iq_pkg::WORD_W,
    parameter int AW    = rx_iq_pkg::PTR_W
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    // Read address is the post-edge head pointer, so o_rdata already holds the head
    // when the next pop arrives; a same-edge write to that address is forwarded.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            o_rdata <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end
endmodule

// File: rtl/rx_iq_fifo.sv
// rtl/rx_iq_fifo.sv - RX I/Q sample FIFO: DEPTH-word memory plus one output register
module rx_iq_fifo
    import rx_iq_pkg::*;
#(
    parameter int DEPTH = rx_iq_pkg::DEPTH,
    parameter int IQ_W  = rx_iq_pkg::IQ_W
) (
    input  logic         clk_in,
    input  logic         reset_n,
    rx_iq_fifo_if.slave  bus
);
    localparam int A_W = $clog2(DEPTH);
    localparam int C_W = A_W + 1;
    localparam int M_W = 2 * IQ_W;

    logic [A_W-1:0]         r_rd_ptr, r_wr_ptr;
    logic [C_W-1:0]         r_count;
    logic                   r_out_valid;
    logic                   r_rclk_d;
    logic signed [IQ_W-1:0] r_rx_i, r_rx_q;
    logic [LEVEL_W-1:0]     r_level;
    logic                   r_overrun, r_underrun;

    logic [A_W-1:0]         w_rd_ptr_nxt, w_wr_ptr_nxt;
    logic [C_W-1:0]         w_count_nxt;
    logic                   w_out_valid_nxt;
    logic                   w_we, w_load_mem, w_load_in;
    logic                   w_ovr_set, w_udr_set;
    logic                   w_pop, w_push, w_mem_empty, w_mem_full;
    logic [M_W-1:0]         w_rdata;
    logic [LEVEL_W-1:0]     w_level_nxt;

    assign w_pop       = bus.IQ_RX_READ_REQ & bus.IQ_RX_READ_CLK & ~r_rclk_d;
    assign w_push      = bus.IQ_RX_READ_REQ & bus.iq_valid;
    assign w_mem_empty = (r_count == '0);
    assign w_mem_full  = (r_count == C_W'(DEPTH));

    always_comb begin
        w_rd_ptr_nxt    = r_rd_ptr;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_count_nxt     = r_count;
        w_out_valid_nxt = r_out_valid;
        w_we            = 1'b0;
        w_load_mem      = 1'b0;
        w_load_in       = 1'b0;
        w_ovr_set       = 1'b0;
        w_udr_set       = 1'b0;
        if (!bus.IQ_RX_READ_REQ) begin
            w_rd_ptr_nxt    = '0;
            w_wr_ptr_nxt    = '0;
            w_count_nxt     = '0;
            w_out_valid_nxt = 1'b0;
        end else if (w_pop) begin
            w_udr_set = ~r_out_valid;
            if (!w_mem_empty) begin
                w_load_mem      = 1'b1;
                w_rd_ptr_nxt    = r_rd_ptr + A_W'(1);
                w_out_valid_nxt = 1'b1;
                if (w_push) begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + A_W'(1);
                end else begin
                    w_count_nxt = r_count - C_W'(1);
                end
            end else if (w_push) begin
                w_load_in       = 1'b1;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_push) begin
            if (!r_out_valid && w_mem_empty) begin
                w_load_in       = 1'b1;
                w_out_valid_nxt = 1'b1;
            end else if (!w_mem_full) begin
                w_we         = 1'b1;
                w_wr_ptr_nxt = r_wr_ptr + A_W'(1);
                w_count_nxt  = r_count + C_W'(1);
            end else begin
                w_ovr_set = 1'b1;
            end
        end
    end

    assign w_level_nxt = LEVEL_W'(w_count_nxt) + LEVEL_W'(w_out_valid_nxt);

    iq_dpram #(
        .DEPTH (DEPTH),
        .W     (M_W),
        .AW    (A_W)
    ) u_mem (
        .clk     (clk_in),
        .i_we    (w_we & reset_n),
        .i_waddr (r_wr_ptr),
        .i_wdata ({bus.RX_Q_in, bus.RX_I_in}),
        .i_raddr (reset_n ? w_rd_ptr_nxt : '0),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_rclk_d    <= 1'b0;
            r_rx_i      <= '0;
            r_rx_q      <= '0;
            r_level     <= '0;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_rclk_d    <= bus.IQ_RX_READ_CLK;
            r_level     <= w_level_nxt;
            if (w_load_mem) begin
                r_rx_i <= w_rdata[IQ_W-1:0];
                r_rx_q <= w_rdata[M_W-1:IQ_W];
            end else if (w_load_in) begin
                r_rx_i <= bus.RX_I_in;
                r_rx_q <= bus.RX_Q_in;
            end
            // A set event in the same cycle as overrun_clear keeps the flag set.
            r_overrun  <= w_ovr_set | (r_overrun & ~bus.overrun_clear);
            r_underrun <= w_udr_set | (r_underrun & ~bus.overrun_clear);
        end
    end

    assign bus.RX_I        = r_rx_i;
    assign bus.RX_Q        = r_rx_q;
    assign bus.fifo_level  = r_level;
    assign bus.iq_overrun  = r_overrun;
    assign bus.iq_underrun = r_underrun;
endmodule

// File: tb/tb_rx_iq_fifo.sv
// tb/tb_rx_iq_fifo.sv - randomized and directed bench for rx_iq_fifo against a queue model
module tb_rx_iq_fifo;
    localparam int D = 32;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_iq_fifo_if #(.IQ_W(W)) bus ();

    rx_iq_fifo #(.DEPTH(D), .IQ_W(W)) dut (
        .clk_in  (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    logic [63:0]    m_q[$];
    logic signed [W-1:0] m_i, m_qv;
    logic           m_ovr, m_udr, m_rclk_prev;
    int             n_chk = 0;
    int             n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_i = '0;
        m_qv = '0;
        m_ovr = 1'b0;
        m_udr = 1'b0;
        m_rclk_prev = 1'b0;
    endtask

    // Queue holds every stored pair; element 0 is the one presented on RX_I/RX_Q.
    task automatic model_edge();
        bit pop, push, ovr_set, udr_set;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pop  = bus.IQ_RX_READ_REQ && bus.IQ_RX_READ_CLK && !m_rclk_prev;
        push = bus.IQ_RX_READ_REQ && bus.iq_valid;
        ovr_set = 0;
        udr_set = 0;
        m_rclk_prev = bus.IQ_RX_READ_CLK;
        if (!bus.IQ_RX_READ_REQ) begin
            m_q.delete();
        end else if (pop) begin
            if (m_q.size() == 0) udr_set = 1;
            else void'(m_q.pop_front());
            if (push) m_q.push_back({bus.RX_Q_in, bus.RX_I_in});
        end else if (push) begin
            if (m_q.size() < D + 1) m_q.push_back({bus.RX_Q_in, bus.RX_I_in});
            else ovr_set = 1;
        end
        if (m_q.size() > 0) {m_qv, m_i} = m_q[0];
        m_ovr = ovr_set | (m_ovr & ~bus.overrun_clear);
        m_udr = udr_set | (m_udr & ~bus.overrun_clear);
    endtask

    task automatic check_all();
        chk("rx_i", bus.RX_I, m_i);
        chk("rx_q", bus.RX_Q, m_qv);
        chk("level", bus.fifo_level, m_q.size());
        chk("overrun", bus.iq_overrun, m_ovr);
        chk("underrun", bus.iq_underrun, m_udr);
    endtask

    task automatic cyc(input bit req, input bit v, input logic [31:0] i, input logic [31:0] q,
                       input bit rclk, input bit clr);
        bus.IQ_RX_READ_REQ = req;
        bus.iq_valid       = v;
        bus.RX_I_in        = i;
        bus.RX_Q_in        = q;
        bus.IQ_RX_READ_CLK = rclk;
        bus.overrun_clear  = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic push(input logic [31:0] i, input logic [31:0] q);
        cyc(1, 1, i, q, 0, 0);
    endtask

    task automatic pop();
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    int exp_i[3] = '{2, 3, 3};

    initial begin
        bus.RX_I_in = '0; bus.RX_Q_in = '0; bus.iq_valid = 0;
        bus.IQ_RX_READ_REQ = 0; bus.IQ_RX_READ_CLK = 0; bus.overrun_clear = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Three pairs, three spaced pops
        push(1, -1); push(2, -2); push(3, -3);
        chk("t1_lvl3", bus.fifo_level, 3);
        chk("t1_i1", bus.RX_I, 1);
        chk("t1_q1", bus.RX_Q, -1);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0, 1, 0);
            chk("t1_lvl", bus.fifo_level, 2 - k);
            chk("t1_i", bus.RX_I, exp_i[k]);
            chk("t1_q", bus.RX_Q, -exp_i[k]);
            repeat (7) cyc(1, 0, 0, 0, 0, 0);
        end
        chk("t1_noflag", {bus.iq_overrun, bus.iq_underrun}, 0);

        // Overfill by one
        for (int n = 0; n < 34; n++) begin
            push(100 + n, -(100 + n));
            if (n == 32) chk("t2_lvl33", bus.fifo_level, 33);
            if (n == 32) chk("t2_no_ovr", bus.iq_overrun, 0);
        end
        chk("t2_ovr", bus.iq_overrun, 1);
        chk("t2_lvl", bus.fifo_level, 33);
        repeat (32) pop();
        chk("t2_last", bus.RX_I, 132);
        cyc(1, 0, 0, 0, 0, 1);
        chk("t2_clr", bus.iq_overrun, 0);
        pop();
        chk("t2_empty", bus.fifo_level, 0);

        // Underrun, then push+pop at full memory
        pop();
        chk("t3_udr", bus.iq_underrun, 1);
        chk("t3_hold", bus.RX_I, 132);
        cyc(1, 0, 0, 0, 0, 1);
        for (int n = 0; n < 33; n++) push(200 + n, 7);
        cyc(1, 1, 555, 556, 1, 0);
        chk("t3_pp_lvl", bus.fifo_level, 33);
        chk("t3_pp_ovr", bus.iq_overrun, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Held READ_CLK pops once; REQ drop flushes
        repeat (13) pop();
        repeat (10) cyc(1, 0, 0, 0, 1, 0);
        chk("t4_one_pop", bus.fifo_level, 19);
        push(300, 301);
        chk("t4_lvl20", bus.fifo_level, 20);
        cyc(0, 1, 9, 9, 0, 0);
        chk("t4_flush", bus.fifo_level, 0);
        repeat (3) cyc(0, 1, 9, 9, 0, 0);
        chk("t4_ignored", bus.fifo_level, 0);
        push(400, -400);
        chk("t4_direct", bus.RX_I, 400);

        // Asynchronous reset mid-stream
        push(401, 1); push(402, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_i0", bus.RX_I, 0);
        chk("t5_lvl0", bus.fifo_level, 0);
        model_reset();
        cyc(1, 1, 5, 5, 0, 0);
        #2 rst_n = 1'b1;
        push(77, -77);
        chk("t5_first", bus.RX_I, 77);
        chk("t5_lvl1", bus.fifo_level, 1);

        // Randomized traffic with phases of fill and drain bias
        for (int n = 0; n < 1200; n++) begin
            int pp;
            bit req, rc;
            pp  = ((n / 150) % 2 == 0) ? 75 : 25;
            req = ($urandom_range(99) >= 2);
            rc  = ($urandom_range(99) < 50);
            cyc(req, $urandom_range(99) < pp, $urandom, $urandom, rc,
                $urandom_range(99) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_iq_fifo.md
RX_IQ_FIFO -- requirements
Module: rx_iq_fifo

Interface
REQ-001 Parameter: DEPTH, default 32, number of I/Q pair storage words in memory (power of two).
REQ-002 Parameter: IQ_W, default 32, width of each I and Q sample.
REQ-003 clk_in  input  1  sole clock, rising-edge; the block is synchronous to one clock, the same clock as the STM32 bus interface.
REQ-004 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 RX_I_in  input  IQ_W  signed I sample from the decimator.
REQ-006 RX_Q_in  input  IQ_W  signed Q sample from the decimator.
REQ-007 iq_valid  input  1  one-cycle strobe: RX_I_in/RX_Q_in hold a new pair.
REQ-008 IQ_RX_READ_REQ  input  1  level from bus interface: host is streaming RX IQ.
REQ-009 IQ_RX_READ_CLK  input  1  from bus interface; the rising edge means the current output pair has been consumed.
REQ-010 overrun_clear  input  1  one-cycle pulse clearing sticky flags.
REQ-011 RX_I  output  IQ_W  signed I of the pair to be read next, registered.
REQ-012 RX_Q  output  IQ_W  signed Q of the pair to be read next, registered.
REQ-013 fifo_level  output  6  number of pairs held, counting memory plus output register (0..DEPTH+1).
REQ-014 iq_overrun  output  1  sticky: an incoming pair was dropped.
REQ-015 iq_underrun  output  1  sticky: the host consumed a stale pair.

Function
REQ-016 Storage shall be DEPTH words of 2*IQ_W bits, with {Q,I} packed, plus one output register with an out_valid flag; total capacity is DEPTH+1.
REQ-017 Pop event shall be IQ_RX_READ_CLK=1 while its value registered on the previous cycle is 0; RX_I/RX_Q shall update at that same clk_in edge, giving 1-cycle latency.
REQ-018 On pop with a non-empty memory: the head word is loaded into RX_I/RX_Q, the read pointer increments, and out_valid=1.
REQ-019 On pop with an empty memory and no push: RX_I/RX_Q hold their value and out_valid=0.
REQ-020 On pop while out_valid=0: iq_underrun is set.
REQ-021 On push with out_valid=0 and an empty memory: the pair loads directly into the output register and out_valid=1; the memory is untouched.
REQ-022 On push otherwise: the pair is written at the write pointer, which then increments.
REQ-023 Push and pop in the same cycle with an empty memory: the incoming pair goes directly to the output register and out_valid=1; REQ-020 still applies.
REQ-024 Push and pop in the same cycle with a full memory: the head moves to the output and the incoming pair is written; no drop and no overrun.
REQ-025 Push with a full memory and no pop: the pair is dropped, pointers are unchanged, and iq_overrun is set.
REQ-026 Pointers shall be log2(DEPTH) bits wide and wrap modulo DEPTH; full/empty shall be derived from a separate count (0..DEPTH), not from pointer equality.
REQ-027 While IQ_RX_READ_REQ=0: pointers, count, and out_valid clear each cycle, pushes are discarded without setting a flag, and RX_I/RX_Q hold their value.
REQ-028 The first push after IQ_RX_READ_REQ rises shall follow REQ-021.
REQ-029 If overrun_clear and a set event occur in the same cycle, the set wins.
REQ-030 fifo_level shall equal count + out_valid and shall be registered, updating on the same edge as the data.

Reset
REQ-031 While reset_n=0, the block shall drive RX_I=0, RX_Q=0, fifo_level=0, iq_overrun=0, iq_underrun=0, clear pointers, count, out_valid and the READ_CLK history register, and leave memory contents undefined.
REQ-032 Assertion of reset_n mid-operation shall abort any push or pop immediately, with no partial update; the first push is accepted at the first edge after release.

Structure
REQ-033 The shared package rx_iq_pkg shall hold IQ_W, DEPTH, the derived pointer width, and the packed {Q,I} word width, for reuse by the decimator and the bus interface.
REQ-034 Memory shall be one sub-module, iq_dpram: simple dual-port, registered write, with read-address logic arranged so that the head data is available at the pop edge (show-ahead); synthesizable to one M9K.
REQ-035 The top level holds the control, flags, and output register; no other sub-modules.

Verification
REQ-036 REQ=1; push pairs (I,Q)=(1,-1),(2,-2),(3,-3); pulse READ_CLK 3 times, 8 cycles apart -> outputs 1/-1 before the first pulse, then 2/-2, then 3/-3; level 3->2->1->0; no flags.
REQ-037 Push 34 pairs with no pops -> level 33, iq_overrun=1 on the 34th push; the 34th pair is never output; overrun_clear -> flag 0.
REQ-038 Level 0, out_valid=0, READ_CLK pulse -> iq_underrun=1, outputs unchanged; push and pop in the same cycle at memory-full -> level unchanged, no overrun.
REQ-039 Hold READ_CLK high for 10 cycles -> exactly one pop; drop IQ_RX_READ_REQ with level 20 -> level 0 on the next edge, and pushes ignored until REQ rises.
REQ-040 Assert reset_n mid-stream, asynchronously between edges -> all outputs 0 without waiting for a clock edge; after release, the first push appears at the output 1 cycle later.
